// File: rtl/conv_pixel_streamer_if.sv
// Frame-load write port, start control and the pixel/result stream
// between a host and conv_pixel_streamer.
interface conv_pixel_streamer_if #(
    parameter int DATA_WIDTH = 16,
    parameter int IMAGE_SIZE = 28,
    parameter int ADDR_W     = $clog2(IMAGE_SIZE**2),
    parameter int COORD_W    = $clog2(IMAGE_SIZE)
);
    logic                  img_wr_en;
    logic [ADDR_W-1:0]     img_wr_addr;
    logic [DATA_WIDTH-1:0] img_wr_data;
    logic                  start;
    logic [DATA_WIDTH-1:0] pixel_out;
    logic                  result_valid;
    logic [COORD_W-1:0]    result_row;
    logic [COORD_W-1:0]    result_col;
    logic                  busy;
    logic                  done;

    modport master (
        output img_wr_en, img_wr_addr, img_wr_data, start,
        input  pixel_out, result_valid, result_row, result_col, busy, done
    );

    modport slave (
        input  img_wr_en, img_wr_addr, img_wr_data, start,
        output pixel_out, result_valid, result_row, result_col, busy, done
    );
endinterface

// File: rtl/conv_pixel_streamer.sv
// Holds one frame and streams it gap-free into the convolution datapath,
// flagging which combinational datapath results are complete windows.
module conv_pixel_streamer #(
    parameter int DATA_WIDTH  = 16,
    parameter int KERNEL_SIZE = 5,
    parameter int IMAGE_SIZE  = 28,
    parameter int ADDR_W      = $clog2(IMAGE_SIZE**2),
    parameter int COORD_W     = $clog2(IMAGE_SIZE)
) (
    input logic                   clk,
    input logic                   reset,
    conv_pixel_streamer_if.slave  bus
);
    localparam int NPIX = IMAGE_SIZE * IMAGE_SIZE;
    localparam logic [ADDR_W-1:0]  LAST_K   = ADDR_W'(NPIX - 1);
    localparam logic [ADDR_W:0]    NPIX_EXT = (ADDR_W + 1)'(NPIX);
    localparam logic [COORD_W-1:0] LAST_COL = COORD_W'(IMAGE_SIZE - 1);
    localparam logic [COORD_W-1:0] EDGE     = COORD_W'(KERNEL_SIZE - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, STREAM = 2'd1, FLUSH = 2'd2} state_t;

    state_t                state, state_nx;
    logic [ADDR_W-1:0]     k;
    logic [COORD_W-1:0]    row, col;
    logic [DATA_WIDTH-1:0] frame [NPIX];
    logic [DATA_WIDTH-1:0] pixel_q;
    logic                  valid_q;
    logic [COORD_W-1:0]    rrow_q, rcol_q;
    logic                  busy_c, done_c;
    logic                  last_pix, win_ok, load_pix;
    logic [ADDR_W-1:0]     rd_addr;

    assign last_pix = (k == LAST_K);
    assign win_ok   = (row >= EDGE) && (col >= EDGE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (bus.start) state_nx = STREAM;
            STREAM:  if (last_pix)  state_nx = FLUSH;
            FLUSH:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy_c = (state != IDLE);
        done_c = (state == FLUSH);
    end

    // pixel_out is registered, so the buffer is read one index ahead of k
    always_comb begin
        load_pix = ((state == IDLE) && bus.start) || ((state == STREAM) && !last_pix);
        rd_addr  = (state == STREAM) ? k + ADDR_W'(1) : '0;
    end

    always_ff @(posedge clk) begin
        if (bus.img_wr_en && (state == IDLE) && ({1'b0, bus.img_wr_addr} < NPIX_EXT))
            frame[bus.img_wr_addr] <= bus.img_wr_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            k       <= '0;
            row     <= '0;
            col     <= '0;
            pixel_q <= '0;
            valid_q <= 1'b0;
            rrow_q  <= '0;
            rcol_q  <= '0;
        end else begin
            pixel_q <= load_pix ? frame[rd_addr] : '0;
            valid_q <= (state == STREAM) && win_ok;
            if ((state == STREAM) && win_ok) begin
                rrow_q <= row - EDGE;
                rcol_q <= col - EDGE;
            end
            if (state == STREAM) begin
                k <= k + ADDR_W'(1);
                if (col == LAST_COL) begin
                    col <= '0;
                    row <= row + COORD_W'(1);
                end else begin
                    col <= col + COORD_W'(1);
                end
            end else begin
                k   <= '0;
                row <= '0;
                col <= '0;
            end
        end
    end

    assign bus.pixel_out    = pixel_q;
    assign bus.result_valid = valid_q;
    assign bus.result_row   = rrow_q;
    assign bus.result_col   = rcol_q;
    assign bus.busy         = busy_c;
    assign bus.done         = done_c;
endmodule
